// File: rtl/burst_mem_responder.sv
// Burst memory responder: stores 256-bit lines, accepts 4-beat write bursts and
// line reads, and returns each read as 4 back-to-back 64-bit beats after a fixed latency.
module burst_mem_responder #(
  parameter int LINES        = 256,
  parameter int READ_LATENCY = 4,
  parameter int QDEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_wdata,
  output logic        mem_ready,
  output logic [63:0] mem_rdata,
  output logic [31:0] mem_raddr,
  output logic        mem_rvalid,
  output logic        protocol_err
);

  localparam int IW = $clog2(LINES);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = $clog2(READ_LATENCY + 1);

  logic [255:0]  r_store [LINES];
  logic [IW-1:0] r_widx;
  logic [1:0]    r_wcnt;

  logic [31:0]   r_qaddr [QDEPTH];
  logic [255:0]  r_qline [QDEPTH];
  logic [AW-1:0] r_qage  [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          r_rvalid;
  logic [1:0]    r_beat;
  logic [63:0]   r_rdata;
  logic [31:0]   r_raddr;
  logic          r_perr;

  logic          w_idle;
  logic          w_ready;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [IW-1:0] w_ridx;
  logic [IW-1:0] w_wr_idx;
  logic          w_pop;
  logic [PW-1:0] w_next_ptr;
  logic          w_head_ok;
  logic          w_next_ok;
  logic          w_start;
  logic [PW-1:0] w_start_ptr;
  logic [1:0]    w_beat_nx;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_idle    = (r_wcnt == 2'd0);
  assign w_ready   = !w_idle || (r_count < CW'(QDEPTH));
  assign mem_ready = w_ready && !rst;

  // Idle read+write: the read wins; mid-burst the write wins and the read is dropped.
  assign w_rd_acc  = mem_read && mem_ready && w_idle;
  assign w_wr_acc  = mem_write && mem_ready && !(w_idle && mem_read);
  assign w_ridx    = mem_addr[5+IW-1:5];
  assign w_wr_idx  = w_idle ? mem_addr[5+IW-1:5] : r_widx;

  // Eligibility is judged one cycle early because the return outputs are registered.
  assign w_pop       = r_rvalid && (r_beat == 2'd3);
  assign w_next_ptr  = f_inc(r_rd_ptr);
  assign w_head_ok   = (r_count != '0) && (r_qage[r_rd_ptr] >= AW'(READ_LATENCY - 1));
  assign w_next_ok   = (r_count > CW'(1)) && (r_qage[w_next_ptr] >= AW'(READ_LATENCY - 1));
  assign w_start     = r_rvalid ? (w_pop && w_next_ok) : w_head_ok;
  assign w_start_ptr = r_rvalid ? w_next_ptr : r_rd_ptr;
  assign w_beat_nx   = r_beat + 2'd1;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_store[w_wr_idx][{r_wcnt, 6'd0} +: 64] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_qaddr[r_wr_ptr] <= mem_addr;
      r_qline[r_wr_ptr] <= r_store[w_ridx];
    end
  end

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_age
      always_ff @(posedge clk) begin
        if (w_rd_acc && (r_wr_ptr == PW'(gi))) begin
          r_qage[gi] <= '0;
        end else if (r_qage[gi] != AW'(READ_LATENCY)) begin
          r_qage[gi] <= r_qage[gi] + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= 2'd0;
      r_widx <= '0;
    end else if (w_wr_acc) begin
      r_wcnt <= r_wcnt + 2'd1;
      if (w_idle) begin
        r_widx <= w_ridx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_rd_acc) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= w_next_ptr;
      end
      case ({w_rd_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_beat   <= 2'd0;
      r_rdata  <= '0;
      r_raddr  <= '0;
    end else if (w_start) begin
      r_rvalid <= 1'b1;
      r_beat   <= 2'd0;
      r_raddr  <= r_qaddr[w_start_ptr];
      r_rdata  <= r_qline[w_start_ptr][63:0];
    end else if (w_pop) begin
      r_rvalid <= 1'b0;
      r_beat   <= 2'd0;
    end else if (r_rvalid) begin
      r_beat   <= w_beat_nx;
      r_rdata  <= r_qline[r_rd_ptr][{w_beat_nx, 6'd0} +: 64];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (mem_read && (mem_write || !w_idle)) begin
      r_perr <= 1'b1;
    end
  end

  assign mem_rvalid   = r_rvalid;
  assign mem_rdata    = r_rdata;
  assign mem_raddr    = r_raddr;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: a line-store model snapshots each
// accepted read into an expected-beat queue that the return monitor drains.
module tb_burst_mem_responder;

  localparam int RL = 4;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [63:0] mem_wdata = '0;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [31:0] mem_raddr;
  logic        mem_rvalid;
  logic        protocol_err;

  burst_mem_responder #(.LINES(256), .READ_LATENCY(RL), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  beat_t        exp_q[$];
  logic [255:0] model [256];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Return monitor: each rvalid beat is matched against the scoreboard head.
  int mon_beat = 0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      mon_beat = 0;
    end else begin
      if (mon_beat != 0) chk("beat_contiguous", 64'(mem_rvalid), 64'd1);
      if (mem_rvalid) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("raddr", 64'(mem_raddr), 64'(e.a));
          chk("rdata", mem_rdata, e.d);
        end
        if (mon_beat == 3) $display("RET addr=%h last=%h", mem_raddr, mem_rdata);
        mon_beat = (mon_beat + 1) % 4;
      end else begin
        mon_beat = 0;
      end
    end
  end

  task automatic rd(input logic [31:0] a, output int t_acc);
    int b = 0;
    @(negedge clk);
    mem_addr = a;
    mem_read = 1'b1;
    while (!mem_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("rd_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back('{a: a, d: model[a[12:5]][k*64 +: 64]});
    #1;
    mem_read = 1'b0;
    t_acc = cyc;
    $display("RD  addr=%h cyc=%0d", a, t_acc);
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [255:0] l, input int gap);
    int b;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) repeat (gap) @(negedge clk);
      @(negedge clk);
      mem_write = 1'b1;
      mem_addr  = (k == 0) ? a : 32'hFFFF_FFE0;
      mem_wdata = l[k*64 +: 64];
      b = 0;
      while (!mem_ready && b < 200) begin
        @(negedge clk);
        b++;
      end
      @(posedge clk);
      model[a[12:5]][k*64 +: 64] = l[k*64 +: 64];
      #1;
      mem_write = 1'b0;
    end
    $display("WR  addr=%h gap=%0d", a, gap);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || mem_rvalid) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int b;
    int hits;
    logic [255:0] la;
    logic [255:0] lb;

    // Reset values while rst is high
    #1;
    chk("rst_rvalid", 64'(mem_rvalid), 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    chk("rst_raddr", 64'(mem_raddr), 64'd0);
    chk("rst_perr", 64'(protocol_err), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(mem_ready), 64'd1);

    // Preload lines used later
    la = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
          64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    wr_line(32'h100, la, 0);
    for (int i = 0; i < 5; i++) wr_line(32'(i * 32), rand_line(), 0);
    wr_line(32'h200, rand_line(), 0);

    // Single read: latency and data
    rd(32'h100, t);
    b = 0;
    while (!mem_rvalid && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("read_latency", 64'(cyc - t), 64'(RL));
    drain();
    chk("perr_clean", 64'(protocol_err), 64'd0);

    // Fill the queue, fifth read waits for space; 16 contiguous return beats
    for (int i = 0; i < 4; i++) rd(32'(i * 32), t);
    @(negedge clk);
    chk("full_ready", 64'(mem_ready), 64'd0);
    fork
      rd(32'h80, t);
      begin
        int w = 0;
        while (!mem_rvalid && w < 50) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 16; i++) begin
          chk("contig16", 64'(mem_rvalid), 64'd1);
          @(negedge clk);
        end
      end
    join
    drain();

    // Queued read keeps its snapshot across a later write
    lb = {64'hB3B3_B3B3_0000_0003, 64'hB2B2_B2B2_0000_0002,
          64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000};
    rd(32'h40, t);
    wr_line(32'h40, lb, 0);
    drain();
    rd(32'h40, t);
    drain();

    // Stalled write burst
    wr_line(32'h300, rand_line(), 2);
    chk("stall_perr", 64'(protocol_err), 64'd0);
    rd(32'h300, t);
    drain();

    // Read and write together while idle: read queued, write dropped
    @(negedge clk);
    mem_addr  = 32'h200;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back('{a: 32'h200, d: model[8'h10][k*64 +: 64]});
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("RDWR addr=00000200");
    @(negedge clk);
    chk("perr_set", 64'(protocol_err), 64'd1);
    drain();
    rd(32'h200, t);
    drain();
    chk("perr_sticky", 64'(protocol_err), 64'd1);

    // Reset during beat 2 of a return with another read queued
    rd(32'h0, t);
    rd(32'h20, t);
    b = 0;
    while (!mem_rvalid && b < 50) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", 64'(mem_rvalid), 64'd0);
    chk("rst_mid_ready", 64'(mem_ready), 64'd0);
    chk("rst_mid_perr", 64'(protocol_err), 64'd0);
    exp_q.delete();
    $display("RST during return");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 64'(mem_ready), 64'd1);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_rvalid) hits++;
    end
    chk("no_return_after_rst", 64'(hits), 64'd0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
